// File: rtl/core_rtr_pkg.sv
// Shared opcodes, status codes and FSM state type for core_ready_to_run_responder.
package core_rtr_pkg;

    localparam logic [15:0] CMD_STATUS      = 16'h0000;
    localparam logic [15:0] CMD_RESET_ENTER = 16'h0010;
    localparam logic [15:0] CMD_RESET_EXIT  = 16'h0011;

    localparam logic [15:0] STAT_BOOTING = 16'h0001;
    localparam logic [15:0] STAT_SETUP   = 16'h0002;
    localparam logic [15:0] STAT_READY   = 16'h0003;
    localparam logic [15:0] STAT_RUNNING = 16'h0004;
    localparam logic [15:0] STAT_UNKNOWN = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        RESPOND = 2'd2
    } rtr_state_e;

    // Priority of reported core state: running beats ready beats setup.
    function automatic logic [15:0] core_status(input logic running,
                                                input logic qualified,
                                                input logic in_reset);
        logic [15:0] stat;
        if (running) begin
            stat = STAT_RUNNING;
        end else if (qualified) begin
            stat = STAT_READY;
        end else if (in_reset) begin
            stat = STAT_SETUP;
        end else begin
            stat = STAT_BOOTING;
        end
        return stat;
    endfunction

endpackage

// File: rtl/core_ready_to_run_if.sv
// Producer/responder handshake: producer raises valid, responder pulses done.
interface core_ready_to_run_if;
    logic valid;
    logic done;

    modport responder (input valid, output done);
    modport producer  (output valid, input done);
endinterface

// File: rtl/rtr_stable_counter.sv
// Saturating counter qualifying how long valid has been continuously high.
module rtr_stable_counter #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    output logic qualified,
    output logic qualified_nxt
);
    localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);

    logic [15:0] stable_cnt_q;
    logic [15:0] stable_cnt_d;

    // Next count: clear on valid low, otherwise count up to the limit.
    always_comb begin
        stable_cnt_d = 16'd0;
        if (!valid) begin
            stable_cnt_d = 16'd0;
        end else if (stable_cnt_q == STABLE_MAX) begin
            stable_cnt_d = stable_cnt_q;
        end else begin
            stable_cnt_d = stable_cnt_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt_q <= 16'd0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
        end
    end

    assign qualified     = (stable_cnt_q == STABLE_MAX);
    assign qualified_nxt = (stable_cnt_d == STABLE_MAX);

endmodule

// File: rtl/core_ready_to_run_responder.sv
// Host command responder for the core_ready_to_run handshake.
// Optional response timeout enabled by defining CORE_RTR_TIMEOUT_EN.
module core_ready_to_run_responder
    import core_rtr_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        bridge_clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [15:0]                 cmd_opcode,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [15:0]                 resp_status,
    output logic                        resp_error,
    output logic                        resp_timeout,
    core_ready_to_run_if.responder      core_ready_to_run
);
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("core_ready_to_run_responder: parameter out of range");
    end

    rtr_state_e  state_q, state_d;
    logic [15:0] opcode_q, opcode_d;
    logic        running_q, running_d;
    logic        in_reset_q, in_reset_d;
    logic [15:0] status_q, status_d;
    logic        error_q, error_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        qualified_s, qualified_nxt_s;

    rtr_stable_counter #(.STABLE_CYCLES(STABLE_CYCLES)) u_stable (
        .clk           (bridge_clk),
        .reset         (reset),
        .valid         (core_ready_to_run.valid),
        .qualified     (qualified_s),
        .qualified_nxt (qualified_nxt_s)
    );

`ifdef CORE_RTR_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
`endif

    // Next-state, command execution and response registration.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        running_d  = running_q;
        in_reset_d = in_reset_q;
        status_d   = status_q;
        error_d    = error_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
`ifdef CORE_RTR_TIMEOUT_EN
        to_cnt_d   = 32'd0;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    opcode_d = cmd_opcode;
                    state_d  = EXEC;
                    // done is registered, so it is decided from the count the EXEC cycle will see.
                    done_d   = (cmd_opcode == CMD_RESET_EXIT) && !running_q && qualified_nxt_s;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = RESPOND;
                case (opcode_q)
                    CMD_STATUS: begin
                        status_d = core_status(running_q, qualified_s, in_reset_q);
                        error_d  = 1'b0;
                    end
                    CMD_RESET_EXIT: begin
                        if (running_q || qualified_s) begin
                            running_d  = 1'b1;
                            in_reset_d = 1'b0;
                            status_d   = STAT_RUNNING;
                            error_d    = 1'b0;
                        end else begin
                            status_d = STAT_BOOTING;
                            error_d  = 1'b1;
                        end
                    end
                    CMD_RESET_ENTER: begin
                        running_d  = 1'b0;
                        in_reset_d = 1'b1;
                        status_d   = STAT_SETUP;
                        error_d    = 1'b0;
                    end
                    default: begin
                        status_d = STAT_UNKNOWN;
                        error_d  = 1'b1;
                    end
                endcase
            end
            RESPOND: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
`ifdef CORE_RTR_TIMEOUT_EN
                    if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
`else
                    state_d = RESPOND;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESPOND);
    end

    // State and output registers.
    always_ff @(posedge bridge_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            opcode_q     <= 16'd0;
            running_q    <= 1'b0;
            in_reset_q   <= 1'b0;
            status_q     <= 16'd0;
            error_q      <= 1'b0;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            running_q    <= running_d;
            in_reset_q   <= in_reset_d;
            status_q     <= status_d;
            error_q      <= error_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef CORE_RTR_TIMEOUT_EN
    // Response wait counter; restarts on every entry into RESPOND.
    always_ff @(posedge bridge_clk) begin
        if (reset) begin
            to_cnt_q <= 32'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
    assign resp_timeout = timeout_q;
`else
    assign resp_timeout = 1'b0;
    logic unused_timeout_s;
    assign unused_timeout_s = timeout_q;
`endif

    assign cmd_ready              = cmd_ready_q;
    assign resp_valid             = resp_valid_q;
    assign resp_status            = status_q;
    assign resp_error             = error_q;
    assign core_ready_to_run.done = done_q;

endmodule

// File: tb/tb_core_ready_to_run_responder.sv
// Scoreboard bench for core_ready_to_run_responder (STABLE_CYCLES=16, TIMEOUT_CYCLES=8).
module tb_core_ready_to_run_responder;

    typedef struct packed {
        logic [15:0] status;
        logic        error;
    } exp_t;

    logic        bridge_clk = 1'b0;
    logic        reset      = 1'b1;
    logic        cmd_valid  = 1'b0;
    logic [15:0] cmd_opcode = 16'h0000;
    logic        resp_ready = 1'b1;
    logic        cmd_ready;
    logic        resp_valid;
    logic [15:0] resp_status;
    logic        resp_error;
    logic        resp_timeout;

    core_ready_to_run_if rtr_if ();

    core_ready_to_run_responder #(
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .bridge_clk        (bridge_clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_opcode        (cmd_opcode),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_status       (resp_status),
        .resp_error        (resp_error),
        .resp_timeout      (resp_timeout),
        .core_ready_to_run (rtr_if)
    );

    always #5 bridge_clk = ~bridge_clk;

    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;
    int   to_pulses = 0;
    logic done_prev = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response monitor, done pulse width and timeout pulse counting.
    always @(negedge bridge_clk) begin
        if (rtr_if.done) begin
            done_cnt++;
            check_eq("done_width", {31'd0, done_prev}, 32'd0);
        end
        done_prev = rtr_if.done;
        if (resp_timeout) to_pulses++;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: got response 0x%0h with nothing expected", resp_status);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("resp_status", {16'd0, resp_status}, {16'd0, mon_e.status});
                check_eq("resp_error", {31'd0, resp_error}, {31'd0, mon_e.error});
            end
        end
    end

    task automatic wait_cmd_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge bridge_clk);
            n++;
        end
        check_eq("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Issue one command from a negedge; hold > 0 stalls resp_ready for that many cycles.
    task automatic send_cmd(input logic [15:0] op, input logic [15:0] st, input logic er, input int hold);
        wait_cmd_ready();
        exp_q.push_back(exp_t'({st, er}));
        if (hold > 0) resp_ready = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        @(posedge bridge_clk);
        #1 cmd_valid = 1'b0;
        @(negedge bridge_clk);
        check_eq("lat_exec", {31'd0, resp_valid}, 32'd0);
        @(negedge bridge_clk);
        check_eq("lat_resp", {31'd0, resp_valid}, 32'd1);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge bridge_clk);
                check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
                check_eq("hold_status", {16'd0, resp_status}, {16'd0, st});
                check_eq("hold_error", {31'd0, resp_error}, {31'd0, er});
            end
            @(posedge bridge_clk);
            #1 resp_ready = 1'b1;
            @(negedge bridge_clk);
        end
    endtask

    initial begin
        rtr_if.valid = 1'b0;
        repeat (3) @(negedge bridge_clk);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_status", {16'd0, resp_status}, 32'd0);
        check_eq("rst_error", {31'd0, resp_error}, 32'd0);
        check_eq("rst_timeout", {31'd0, resp_timeout}, 32'd0);
        check_eq("rst_done", {31'd0, rtr_if.done}, 32'd0);
        @(posedge bridge_clk);
        #1 reset = 1'b0;
        @(negedge bridge_clk);
        check_eq("cmd_ready_lag", {31'd0, cmd_ready}, 32'd0);
        @(negedge bridge_clk);
        check_eq("cmd_ready_rise", {31'd0, cmd_ready}, 32'd1);

        send_cmd(16'h0000, 16'h0001, 1'b0, 0);

        // 15 valid cycles before EXEC: not yet qualified
        rtr_if.valid = 1'b1;
        repeat (14) @(negedge bridge_clk);
        send_cmd(16'h0000, 16'h0001, 1'b0, 0);

        // restart count, 16 valid cycles: qualified
        rtr_if.valid = 1'b0;
        repeat (2) @(negedge bridge_clk);
        rtr_if.valid = 1'b1;
        repeat (15) @(negedge bridge_clk);
        send_cmd(16'h0000, 16'h0003, 1'b0, 0);

        send_cmd(16'h0011, 16'h0004, 1'b0, 0);
        check_eq("done_first_exit", done_cnt, 32'd1);
        send_cmd(16'h0011, 16'h0004, 1'b0, 0);
        check_eq("done_second_exit", done_cnt, 32'd1);
        send_cmd(16'h0000, 16'h0004, 1'b0, 0);

        send_cmd(16'h0010, 16'h0002, 1'b0, 0);
        rtr_if.valid = 1'b0;
        send_cmd(16'h0011, 16'h0001, 1'b1, 0);
        check_eq("done_unqualified", done_cnt, 32'd1);
        send_cmd(16'h0000, 16'h0002, 1'b0, 0);

        send_cmd(16'h00AB, 16'hFFFF, 1'b1, 50);

        // reset while a response is pending: response is discarded
        wait_cmd_ready();
        resp_ready = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = 16'h0000;
        @(posedge bridge_clk);
        #1 cmd_valid = 1'b0;
        @(posedge bridge_clk);
        #1 check_eq("pre_reset_resp_valid", {31'd0, resp_valid}, 32'd1);
        reset = 1'b1;
        @(posedge bridge_clk);
        #1 check_eq("reset_drop_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("reset_drop_status", {16'd0, resp_status}, 32'd0);
        reset      = 1'b0;
        resp_ready = 1'b1;
        @(negedge bridge_clk);
        send_cmd(16'h0000, 16'h0001, 1'b0, 0);

`ifdef CORE_RTR_TIMEOUT_EN
        begin
            int vcnt = 0;
            wait_cmd_ready();
            resp_ready = 1'b0;
            to_pulses  = 0;
            cmd_valid  = 1'b1;
            cmd_opcode = 16'h0000;
            @(posedge bridge_clk);
            #1 cmd_valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge bridge_clk);
                if (resp_valid) vcnt++;
            end
            check_eq("timeout_valid_cycles", vcnt, 32'd8);
            check_eq("timeout_pulses", to_pulses, 32'd1);
            @(posedge bridge_clk);
            #1 resp_ready = 1'b1;
            @(negedge bridge_clk);
            send_cmd(16'h0000, 16'h0001, 1'b0, 0);
        end
`endif

        repeat (3) @(negedge bridge_clk);
        check_eq("sb_empty", exp_q.size(), 32'd0);
        check_eq("done_total", done_cnt, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
